// File: rtl/score_display.sv
// Binary score (0..2^BW-1) to two multiplexed 7-segment digits via a sequential double-dabble engine.
// Optional build macro SCORE_BLANK_EN: blank a leading zero in the tens slot.
module score_display #(
  parameter int BW          = 7,
  parameter int REFRESH_DIV = 1000
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [BW-1:0] value_i,
  output logic [6:0]    seg_o,
  output logic [1:0]    dig_o,
  output logic          busy_o,
  output logic          overflow_o
);
  localparam int SW = BW + 12;
  localparam int IW = $clog2(BW + 1);
  localparam int RW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] last_q;
  logic [SW-1:0] shift_q, shift_adj;
  logic [IW-1:0] iter_q;
  logic [3:0]    tens_q, ones_q, digit;
  logic          ovf_q;
  logic [RW-1:0] ref_q;
  logic          sel_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (value_i != last_q) state_d = SHIFT;
      SHIFT:   if (iter_q == IW'(BW - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Add-3 on every BCD nibble >= 5 before the shift.
  always_comb begin
    shift_adj = shift_q;
    for (int i = 0; i < 3; i++)
      if (shift_q[BW+4*i +: 4] >= 4'd5)
        shift_adj[BW+4*i +: 4] = shift_q[BW+4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      last_q  <= '0;
      shift_q <= '0;
      iter_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (value_i != last_q) begin
          last_q  <= value_i;
          shift_q <= {12'b0, value_i};
          iter_q  <= '0;
        end
        SHIFT: begin
          shift_q <= shift_adj << 1;
          iter_q  <= iter_q + IW'(1);
        end
        DONE: begin
          tens_q <= shift_q[BW+4 +: 4];
          ones_q <= shift_q[BW   +: 4];
          ovf_q  <= |shift_q[BW+8 +: 4];
        end
        default: ;
      endcase
    end
  end

  // Digit multiplex free-runs, unaffected by conversions.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ref_q <= '0;
      sel_q <= 1'b0;
    end else if (ref_q == RW'(REFRESH_DIV - 1)) begin
      ref_q <= '0;
      sel_q <= ~sel_q;
    end else begin
      ref_q <= ref_q + RW'(1);
    end
  end

  assign digit = sel_q ? tens_q : ones_q;

  always_comb begin
    case (digit)
      4'd0:    seg_o = 7'b0111111;
      4'd1:    seg_o = 7'b0000110;
      4'd2:    seg_o = 7'b1011011;
      4'd3:    seg_o = 7'b1001111;
      4'd4:    seg_o = 7'b1100110;
      4'd5:    seg_o = 7'b1101101;
      4'd6:    seg_o = 7'b1111101;
      4'd7:    seg_o = 7'b0000111;
      4'd8:    seg_o = 7'b1111111;
      4'd9:    seg_o = 7'b1101111;
      default: seg_o = 7'b0000000;
    endcase
    if (ovf_q) seg_o = 7'b1000000;
`ifdef SCORE_BLANK_EN
    else if (sel_q && tens_q == 4'd0) seg_o = 7'b0000000;
`else
`endif
  end

  assign dig_o      = sel_q ? 2'b10 : 2'b01;
  assign busy_o     = (state_q != IDLE);
  assign overflow_o = ovf_q;
endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: directed scenarios plus random scores against a cycle-level display model.
module tb_score_display;
  localparam int BW = 7;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [BW-1:0] value = '0;
  logic [6:0]    seg;
  logic [1:0]    dig;
  logic          busy, ovf;

  score_display #(.BW(BW), .REFRESH_DIV(RD)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .value_i(value),
    .seg_o(seg), .dig_o(dig), .busy_o(busy), .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: last accepted value, value being converted, shown value, cycles left busy, edges since reset.
  int m_last = 0, m_pend = 0, m_disp = 0, m_busy = 0, m_cyc = 0;
  logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                               7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last = 0; m_pend = 0; m_disp = 0; m_busy = 0; m_cyc = 0;
  endtask

  task automatic model_step(input int v);
    m_cyc++;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) m_disp = m_pend;
    end else if (v != m_last) begin
      m_last = v;
      m_pend = v;
      m_busy = BW + 1;
    end
  endtask

  task automatic check_all();
    int sel, d;
    logic [6:0] es;
    sel = (m_cyc / RD) % 2;
    d   = sel ? (m_disp / 10) % 10 : m_disp % 10;
    es  = seg_tab[d];
    if (m_disp >= 100) es = 7'b1000000;
`ifdef SCORE_BLANK_EN
    else if (sel == 1 && m_disp < 10) es = 7'b0000000;
`else
`endif
    chk("seg",      seg,                    es);
    chk("dig",      {5'b0, dig},            sel ? 7'd2 : 7'd1);
    chk("busy",     {6'b0, busy},           {6'b0, m_busy > 0});
    chk("overflow", {6'b0, ovf},            {6'b0, m_disp >= 100});
  endtask

  task automatic tick();
    int v;
    v = int'(value);
    @(posedge clk);
    #1;
    model_step(v);
    check_all();
  endtask

  task automatic run(input int v, input int n);
    value = BW'(v);
    repeat (n) tick();
  endtask

  initial begin
    // Reset state
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;
    repeat (3) tick();

    run(42, 14);
    run(99, 14);
    run(100, 14);
    run(5, 14);
    run(7, 14);
    run(0, 14);

    // New value lands on the third SHIFT cycle: 42 shows first, then 17.
    value = BW'(42);
    repeat (3) tick();
    run(17, 26);

    // Value bounces back to the converted one while busy: no second conversion.
    run(20, 2);
    run(30, 2);
    run(20, 14);

    // Asynchronous reset in the middle of SHIFT.
    value = BW'(63);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_seg",  seg,          7'b0111111);
    chk("rst_dig",  {5'b0, dig},  7'd1);
    chk("rst_busy", {6'b0, busy}, 7'd0);
    chk("rst_ovf",  {6'b0, ovf},  7'd0);
    model_reset();
    #2 rst_n = 1'b1;
    repeat (16) tick();

    // Random scores, held for random durations (often shorter than a conversion).
    repeat (80) run(int'($urandom_range(0, 127)), int'($urandom_range(1, 14)));
    repeat (12) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/score_display.md
# score_display

Display back-end for the scoreboard: takes the binary score from the up/down counter (range 0–99), converts it to two BCD digits with a sequential shift-and-add-3 (double-dabble) engine, and drives a time-multiplexed pair of common-cathode 7-segment digits. It sits directly downstream of the counter and directly upstream of the chip output pins.

## Interface
- `BW`, 7, width of the score input; legal range 4–9.
- `REFRESH_DIV`, 1000, clock cycles per digit slot in the multiplex; must be ≥ 2.

- `clk_i`  in  1  system clock
- `rst_n_i`  in  1  reset, asynchronous, active-low
- `value_i`  in  BW  binary score from the counter (`counter_val_o`)
- `seg_o`  out  7  segments {g,f,e,d,c,b,a}, active high
- `dig_o`  out  2  digit enable, one-hot, active high; bit0 = ones, bit1 = tens
- `busy_o`  out  1  conversion in progress
- `overflow_o`  out  1  displayed value ≥ 100

## Operation
- Registers:
  - `last_q` [BW]: last converted value.
  - `shift_q`: {hundreds[3:0], tens[3:0], ones[3:0], bin[BW-1:0]}.
  - Iteration counter.
  - Display registers `tens_q`, `ones_q`, `ovf_q`.
  - Refresh counter and digit select `sel_q`.
- FSM states:
  - IDLE: each edge, compare `value_i` with `last_q`. On mismatch: `last_q <= value_i`, load `shift_q` = {12'b0, value_i}, clear the iteration counter, go to SHIFT.
  - SHIFT: per cycle, add 3 to each BCD nibble ≥ 5, then shift `shift_q` left by 1. After BW iterations, go to DONE.
  - DONE: `tens_q <= tens`, `ones_q <= ones`, `ovf_q <= (hundreds != 0)`. Return to IDLE.
- `busy_o` = 1 in SHIFT and DONE.
- `value_i` changes during SHIFT/DONE are not sampled. The comparison in the next IDLE cycle picks up the latest value automatically, so no update is lost.
- Multiplex:
  - The refresh counter counts 0..REFRESH_DIV-1.
  - On wrap, `sel_q` toggles. `dig_o` = 2'b01 when `sel_q` = 0, 2'b10 when `sel_q` = 1.
- Segment decode of the selected digit (gfedcba):
  - 0 = 0111111
  - 1 = 0000110
  - 2 = 1011011
  - 3 = 1001111
  - 4 = 1100110
  - 5 = 1101101
  - 6 = 1111101
  - 7 = 0000111
  - 8 = 1111111
  - 9 = 1101111
- Overflow: when `ovf_q` = 1, both digits show a dash (1000000) and `overflow_o` = 1.
- `seg_o`, `dig_o` and `overflow_o` are driven from registers or a decode of registers only. They never glitch on `value_i`.

## Timing
- Reset values:
  - FSM = IDLE, `last_q` = 0, `tens_q` = `ones_q` = 0, `ovf_q` = 0.
  - `sel_q` = 0, refresh counter = 0.
  - Outputs: `seg_o` = 0111111 ('0'), `dig_o` = 01, `busy_o` = 0, `overflow_o` = 0.
- Latency: a change is detected at edge N. Shifts occur at edges N+1..N+BW. Display registers update at edge N+BW+1. `busy_o` is high for exactly BW+1 cycles.
- Back-to-back conversions: the earliest next detection is the edge after DONE, so there is a minimum of one IDLE cycle between conversions.
- Digit period: each digit is enabled for exactly REFRESH_DIV cycles. The multiplex runs continuously and is independent of conversion.
- Reset asserted mid-conversion: all state returns to reset values immediately (asynchronously). After release, if `value_i` ≠ 0, a conversion starts on the first edge.
- If `value_i` returns to `last_q` before IDLE is re-entered, no conversion is started.

## Configuration
- `SCORE_BLANK_EN`:
  - Defined: leading-zero blanking. While the tens slot is selected, `tens_q` = 0 and `ovf_q` = 0, `seg_o` = 0000000. `dig_o` still toggles normally.
  - Undefined: the tens digit always shows its value, including '0'.

## Test plan
- Reset with `value_i` = 0 → `seg_o` = 0111111, `dig_o` = 01, `busy_o` = 0, `overflow_o` = 0; no conversion starts.
- `value_i` 0→42 (BW = 7) → `busy_o` high for 8 cycles; then ones slot shows 1011011 ('2') and tens slot shows 1100110 ('4').
- `value_i` = 99 → both slots 1101111. Then `value_i` = 100 → `overflow_o` = 1 and both slots 1000000. Then 5 → `overflow_o` = 0, ones slot shows 1101101.
- `value_i` = 42, then 17 on the 3rd cycle of SHIFT → 42 displays first. A second conversion starts one cycle after DONE with no further stimulus, and 17 displays.
- REFRESH_DIV = 4 → `dig_o` alternates 01/10 every 4 cycles and the matching digit pattern appears on `seg_o`.
- Pull `rst_n_i` low mid-SHIFT with `value_i` = 63, then release → outputs return to reset values immediately (not at the next edge); after release, 63 displays. With `SCORE_BLANK_EN` and value 7 → tens slot `seg_o` = 0000000.
